// File: rtl/wb_mem_slave_pkg.sv
// Shared integration defines and common types for the wb_mem_slave Wishbone memory.
// Optional feature macro: WB_MEM_ADDR_CHECK_EN (out-of-range address -> err response).
`ifndef WB_MEM_SLAVE_DEFINES
`define WB_MEM_SLAVE_DEFINES
`define CORE_ADDR_WIDTH 32
`define CORE_DATA_WIDTH 32
`define CORE_BE_WIDTH 4
`define WB_MEM_DEF_RD_LATENCY 2
`define WB_MEM_DEF_MAX_OUT 4
`endif

package wb_mem_slave_pkg;

  localparam int CORE_ADDR_WIDTH = `CORE_ADDR_WIDTH;
  localparam int CORE_DATA_WIDTH = `CORE_DATA_WIDTH;
  localparam int CORE_BE_WIDTH   = `CORE_BE_WIDTH;

  // Control part of one response-pipe entry; rd marks entries whose data comes from the RAM.
  typedef struct packed {
    logic val;
    logic err;
    logic rd;
  } wb_rsp_ctl_t;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wb_mem_slave_if.sv
// Pipelined Wishbone B4 request/response bundle between the L1 access unit and wb_mem_slave.
// Signal names are from the slave's point of view.
interface wb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [BE_WIDTH-1:0]   wb_sel_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_stall_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/wb_mem_ram.sv
// Single-port synchronous RAM with byte write enables and registered read.
// No reset on purpose so it maps onto block RAM.
module wb_mem_ram #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [BW-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BW; b++) begin
        if (be[b]) r_mem[addr][b*8 +: 8] <= wd[b*8 +: 8];
      end
    end
    rd <= r_mem[addr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory slave: fixed-latency in-order responses, bounded outstanding count.
// Optional feature macro: WB_MEM_ADDR_CHECK_EN (requests above the memory range return err).
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH      = `CORE_ADDR_WIDTH,
  parameter int DATA_WIDTH      = `CORE_DATA_WIDTH,
  parameter int MEM_AW          = 10,
  parameter int RD_LATENCY      = `WB_MEM_DEF_RD_LATENCY,
  parameter int MAX_OUTSTANDING = `WB_MEM_DEF_MAX_OUT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_mem_slave_if.slave wb
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = cnt_width(MAX_OUTSTANDING);

  logic [CW-1:0]         r_out_cnt;
  wb_rsp_ctl_t           r_ctl [RD_LATENCY];
  wb_rsp_ctl_t           w_ctl0;
  wb_rsp_ctl_t           w_last;
  logic                  w_acc;
  logic                  w_addr_err;
  logic                  w_rsp;
  logic                  w_ram_we;
  logic [MEM_AW-1:0]     w_word;
  logic [DATA_WIDTH-1:0] w_ram_rd;
  logic [DATA_WIDTH-1:0] w_dat0;
  logic [DATA_WIDTH-1:0] w_last_dat;
  logic                  w_unused_adr;

  assign w_word       = wb.wb_adr_i[MEM_AW+1:2];
  assign w_unused_adr = ^wb.wb_adr_i;

`ifdef WB_MEM_ADDR_CHECK_EN
  assign w_addr_err = |wb.wb_adr_i[ADDR_WIDTH-1:MEM_AW+2];
`else
  assign w_addr_err = 1'b0;
`endif

  assign wb.wb_stall_o = (r_out_cnt == CW'(MAX_OUTSTANDING)) | ~wb.wb_cyc_i;
  assign w_acc         = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_stall_o;
  assign w_ram_we      = w_acc & wb.wb_we_i & ~w_addr_err;

  assign w_ctl0.val = w_acc;
  assign w_ctl0.err = w_acc & w_addr_err;
  assign w_ctl0.rd  = w_acc & ~wb.wb_we_i & ~w_addr_err;

  wb_mem_ram #(
    .AW (MEM_AW),
    .DW (DATA_WIDTH),
    .BW (BE_WIDTH)
  ) u_ram (
    .clk  (wb_clk_i),
    .we   (w_ram_we),
    .be   (wb.wb_sel_i),
    .addr (w_word),
    .wd   (wb.wb_dat_i),
    .rd   (w_ram_rd)
  );

  // Cycle abort flushes the pipe and the counter; RAM writes already done stay done.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < RD_LATENCY; i++) r_ctl[i] <= '0;
      r_out_cnt <= '0;
    end else if (!wb.wb_cyc_i) begin
      for (int i = 0; i < RD_LATENCY; i++) r_ctl[i] <= '0;
      r_out_cnt <= '0;
    end else begin
      r_ctl[0] <= w_ctl0;
      for (int i = 1; i < RD_LATENCY; i++) r_ctl[i] <= r_ctl[i-1];
      if (w_acc && !w_rsp)      r_out_cnt <= r_out_cnt + CW'(1);
      else if (!w_acc && w_rsp) r_out_cnt <= r_out_cnt - CW'(1);
    end
  end

  // The RAM output register is pipe stage 0 for data; later stages only shift it along.
  assign w_dat0 = r_ctl[0].rd ? w_ram_rd : '0;

  if (RD_LATENCY > 1) begin : g_dpipe
    logic [DATA_WIDTH-1:0] r_dat [1:RD_LATENCY-1];
    always_ff @(posedge wb_clk_i) begin
      r_dat[1] <= w_dat0;
      for (int i = 2; i < RD_LATENCY; i++) r_dat[i] <= r_dat[i-1];
    end
    assign w_last_dat = r_dat[RD_LATENCY-1];
  end else begin : g_dnopipe
    assign w_last_dat = w_dat0;
  end

  assign w_last = r_ctl[RD_LATENCY-1];

  assign wb.wb_ack_o = wb.wb_cyc_i & w_last.val & ~w_last.err;
`ifdef WB_MEM_ADDR_CHECK_EN
  assign wb.wb_err_o = wb.wb_cyc_i & w_last.val & w_last.err;
`else
  assign wb.wb_err_o = 1'b0;
`endif
  assign wb.wb_dat_o = wb.wb_ack_o ? w_last_dat : '0;
  assign w_rsp       = wb.wb_ack_o | wb.wb_err_o;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: two instances (latency 2 / limit 4, latency 4 / limit 2)
// share one request bus and are each checked every cycle against a queue-based response model.
module tb_wb_mem_slave;

`ifdef WB_MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          err;
    bit          known;
    logic [31:0] dat;
  } pend_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_cyc = 1'b0;
  logic        d_stb = 1'b0;
  logic        d_we  = 1'b0;
  logic [31:0] d_adr = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_dat = '0;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  pend_t       pq [2][$];
  logic [31:0] mm [2][1024];
  logic [3:0]  kn [2][1024];

  logic        o_stall [2];
  logic        o_ack   [2];
  logic        o_err   [2];
  logic [31:0] o_dat   [2];

  always #5 clk = ~clk;

  wb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
  wb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();

  assign if_a.wb_cyc_i = d_cyc;
  assign if_a.wb_stb_i = d_stb;
  assign if_a.wb_we_i  = d_we;
  assign if_a.wb_adr_i = d_adr;
  assign if_a.wb_sel_i = d_sel;
  assign if_a.wb_dat_i = d_dat;
  assign if_b.wb_cyc_i = d_cyc;
  assign if_b.wb_stb_i = d_stb;
  assign if_b.wb_we_i  = d_we;
  assign if_b.wb_adr_i = d_adr;
  assign if_b.wb_sel_i = d_sel;
  assign if_b.wb_dat_i = d_dat;

  assign o_stall[0] = if_a.wb_stall_o;
  assign o_ack[0]   = if_a.wb_ack_o;
  assign o_err[0]   = if_a.wb_err_o;
  assign o_dat[0]   = if_a.wb_dat_o;
  assign o_stall[1] = if_b.wb_stall_o;
  assign o_ack[1]   = if_b.wb_ack_o;
  assign o_err[1]   = if_b.wb_err_o;
  assign o_dat[1]   = if_b.wb_dat_o;

  wb_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .RD_LATENCY(2), .MAX_OUTSTANDING(4)
  ) dut_a (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (if_a)
  );

  wb_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .RD_LATENCY(4), .MAX_OUTSTANDING(2)
  ) dut_b (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb         (if_b)
  );

  function automatic bit addr_err(input logic [31:0] a);
    return CHK && (a[31:12] != 20'd0);
  endfunction

  // Reference: each accepted request is answered exactly lat cycles later unless the cycle drops.
  task automatic model_step(input int k);
    int          lat;
    int          mxo;
    int          w;
    bit          e_stall;
    bit          e_ack;
    bit          e_err;
    bit          dat_ok;
    bit          acc;
    bit          aerr;
    logic [31:0] e_dat;
    pend_t       p;
    lat    = (k == 0) ? 2 : 4;
    mxo    = (k == 0) ? 4 : 2;
    e_ack  = 1'b0;
    e_err  = 1'b0;
    e_dat  = '0;
    dat_ok = 1'b1;
    if (!rst_n) begin
      pq[k].delete();
      e_stall = !d_cyc;
    end else begin
      e_stall = (pq[k].size() == mxo) || !d_cyc;
      if (d_cyc && pq[k].size() != 0 && pq[k][0].due == cyc_n) begin
        e_err = pq[k][0].err;
        e_ack = !pq[k][0].err;
        if (e_ack) begin
          e_dat  = pq[k][0].dat;
          dat_ok = pq[k][0].known;
        end
      end
    end
    checks++;
    if (o_stall[k] !== e_stall || o_ack[k] !== e_ack || o_err[k] !== e_err ||
        (dat_ok && o_dat[k] !== e_dat)) begin
      errors++;
      $display("FAIL cycle_%0d dut%0d stall/ack/err/dat got %b%b%b %h want %b%b%b %h",
               cyc_n, k, o_stall[k], o_ack[k], o_err[k], o_dat[k], e_stall, e_ack, e_err, e_dat);
    end
    if (rst_n) begin
      if (e_ack || e_err) void'(pq[k].pop_front());
      acc = d_cyc && d_stb && !e_stall;
      if (acc) begin
        aerr    = addr_err(d_adr);
        w       = int'(d_adr[11:2]);
        p.due   = cyc_n + lat;
        p.err   = aerr;
        p.known = 1'b1;
        p.dat   = '0;
        if (!d_we && !aerr) begin
          p.dat   = mm[k][w];
          p.known = (kn[k][w] == 4'hF);
        end
        if (d_we && !aerr) begin
          for (int b = 0; b < 4; b++) begin
            if (d_sel[b]) begin
              mm[k][w][b*8 +: 8] = d_dat[b*8 +: 8];
              kn[k][w][b]        = 1'b1;
            end
          end
        end
        pq[k].push_back(p);
      end
      if (!d_cyc) pq[k].delete();
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
    cyc_n++;
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit cyc, input bit stb, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    @(posedge clk);
    #1;
    d_cyc = cyc;
    d_stb = stb;
    d_we  = we;
    d_adr = adr;
    d_sel = sel;
    d_dat = dat;
  endtask

  // One request on an idle bus; returns cycles-to-response as seen on dut_a.
  task automatic single(input string nm, input bit we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output int n, output logic [31:0] rd, output bit er);
    drive(1'b1, 1'b1, we, adr, sel, dat);
    @(negedge clk);
    lit({nm, "_accept_stall"}, 32'(o_stall[0]), 32'd0);
    n  = 99;
    rd = '0;
    er = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      @(negedge clk);
      if (o_ack[0] || o_err[0]) begin
        n  = i;
        rd = o_dat[0];
        er = o_err[0];
        break;
      end
    end
    lit({nm, "_latency"}, 32'(n), 32'd2);
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 63)) << 2) | (32'($urandom) & 32'd3);
    if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin
    int          n;
    int          acc_b;
    int          first_stall;
    int          ack_cnt_a;
    int          ack_cnt_b;
    bit          er;
    bit          stall_or;
    logic [31:0] rd;
    logic [31:0] first_dat;
    logic [31:0] last_dat;
    logic [11:0] pattern;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 1024; w++) begin
        mm[k][w] = '0;
        kn[k][w] = '0;
      end
    end

    repeat (3) @(negedge clk);
    lit("reset_ack", 32'(o_ack[0]), 32'd0);
    lit("reset_dat", o_dat[0], 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    lit("idle_stall_cyc_low", 32'(o_stall[0]), 32'd1);

    // Write then read back.
    single("t1_wr", 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, n, rd, er);
    lit("t1_wr_dat", rd, 32'd0);
    single("t1_rd", 1'b0, 32'h40, 4'h0, 32'd0, n, rd, er);
    lit("t1_rd_dat", rd, 32'hDEADBEEF);

    // Byte enables over a known background.
    single("t2_wr_ff", 1'b1, 32'h80, 4'hF, 32'hFFFFFFFF, n, rd, er);
    single("t2_wr_be", 1'b1, 32'h80, 4'h5, 32'h11223344, n, rd, er);
    single("t2_rd", 1'b0, 32'h80, 4'h0, 32'd0, n, rd, er);
    lit("t2_rd_dat", rd, 32'hFF22FF44);

    // 8-beat line read.
    for (int i = 0; i < 8; i++) begin
      single("t3_fill", 1'b1, 32'h100 + 32'(i * 4), 4'hF, 32'hC0DE0000 | 32'(i), n, rd, er);
    end
    stall_or  = 1'b0;
    pattern   = '0;
    first_dat = '0;
    last_dat  = '0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, c < 8, 1'b0, 32'h100 + 32'(c * 4), 4'h0, 32'd0);
      @(negedge clk);
      if (c < 8) stall_or = stall_or | o_stall[0];
      if (o_ack[0]) pattern[c] = 1'b1;
      if (c == 2) first_dat = o_dat[0];
      if (c == 9) last_dat = o_dat[0];
    end
    lit("t3_stall_seen", 32'(stall_or), 32'd0);
    lit("t3_ack_pattern", 32'(pattern), 32'h3FC);
    lit("t3_first_dat", first_dat, 32'hC0DE0000);
    lit("t3_last_dat", last_dat, 32'hC0DE0007);

    // Outstanding limit on the latency-4 / limit-2 instance.
    repeat (8) drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    acc_b       = 0;
    first_stall = -1;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h104, 4'h0, 32'd0);
      @(negedge clk);
      if (!o_stall[1]) acc_b++;
      else if (first_stall < 0) first_stall = c;
    end
    lit("t4_accepts_in_20", 32'(acc_b), 32'd8);
    lit("t4_first_stall", 32'(first_stall), 32'd2);

    // Cycle abort after three read accepts.
    repeat (8) drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    ack_cnt_a = 0;
    ack_cnt_b = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 3)       drive(1'b1, 1'b1, 1'b0, 32'h108, 4'h0, 32'd0);
      else if (c == 3) drive(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      else             drive(1'b1, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
      @(negedge clk);
      if (c >= 3 && (o_ack[0] || o_err[0])) ack_cnt_a++;
      if (o_ack[1] || o_err[1]) ack_cnt_b++;
      if (c == 4) lit("t5_stall_after_abort", 32'(o_stall[0]), 32'd0);
    end
    lit("t5_acks_a_after_drop", 32'(ack_cnt_a), 32'd0);
    lit("t5_acks_b", 32'(ack_cnt_b), 32'd0);

    // Out-of-range write: err with the check, aliases onto word 0 without it.
    single("t6_wr0", 1'b1, 32'h0, 4'hF, 32'h12345678, n, rd, er);
    single("t6_wr_hi", 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, n, rd, er);
    lit("t6_err_flag", 32'(er), CHK ? 32'd1 : 32'd0);
    lit("t6_err_dat", rd, 32'd0);
    single("t6_rd0", 1'b0, 32'h0, 4'h0, 32'd0, n, rd, er);
    lit("t6_rd0_dat", rd, CHK ? 32'h12345678 : 32'hA5A5A5A5);

    // Randomized traffic with one reset in the middle of a burst.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        d_cyc = 1'b0;
        d_stb = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end else begin
        drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
              rand_adr(), 4'($urandom), $urandom);
      end
    end
    repeat (8) drive(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
